// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide engine for the EX stage.
// Single-edge multiply, 32-step radix-2 restoring divide, flush abort and stall request.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  output logic               busy,
  output logic               stall_req,
  output logic               hl_valid,
  output logic [2*WIDTH-1:0] hl_data
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] lo_sr;    // multiplicand magnitude, then quotient shift register
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem;
  logic             sign_a;
  logic             sign_b;

  logic             signed_op;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;
  logic [2*WIDTH-1:0] div_res;

  always_comb begin
    signed_op = ~op[0];
    a_abs     = (signed_op & src_a[WIDTH-1]) ? -src_a : src_a;
    b_abs     = (signed_op & src_b[WIDTH-1]) ? -src_b : src_b;
  end

  always_comb begin
    trial  = {rem, lo_sr[WIDTH-1]};
    fits   = trial >= {1'b0, b_mag};
    rem_nx = fits ? WIDTH'(trial - {1'b0, b_mag}) : trial[WIDTH-1:0];
    quo_nx = {lo_sr[WIDTH-2:0], fits};
  end

  always_comb begin
    prod    = {{WIDTH{1'b0}}, lo_sr} * {{WIDTH{1'b0}}, b_mag};
    mul_res = (sign_a ^ sign_b) ? -prod : prod;
    // A zero divisor leaves the raw dividend in hi, independent of sign fix-up.
    if (b_mag == '0) begin
      div_res = {a_raw, {WIDTH{1'b1}}};
    end else begin
      div_res[WIDTH-1:0]       = (sign_a ^ sign_b) ? -quo_nx : quo_nx;
      div_res[2*WIDTH-1:WIDTH] = sign_a ? -rem_nx : rem_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_raw   <= '0;
      lo_sr   <= '0;
      b_mag   <= '0;
      rem     <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      hl_data <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_raw  <= src_a;
            lo_sr  <= a_abs;
            b_mag  <= b_abs;
            sign_a <= signed_op & src_a[WIDTH-1];
            sign_b <= signed_op & src_b[WIDTH-1];
            rem    <= '0;
            cnt    <= '0;
            state  <= op[1] ? DIV : MUL;
          end
        end
        MUL: begin
          hl_data <= mul_res;
          state   <= DONE;
        end
        DIV: begin
          rem   <= rem_nx;
          lo_sr <= quo_nx;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            hl_data <= div_res;
            cnt     <= '0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign stall_req = busy | (start & ~flush);
  assign hl_valid  = (state == DONE) & ~flush;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        hl_valid;
  logic [63:0] hl_data;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .hl_valid  (hl_valid),
    .hl_data   (hl_data)
  );

  typedef struct {
    logic [63:0] data;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [63:0] last_hl = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (o)
      2'b00: res = 64'(sa * sb_);
      2'b01: res = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          q   = sa / sb_;
          r   = sa % sb_;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (hl_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {63'b0, hl_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("hl_data", hl_data, e.data);
          check("latency", 64'(cyc - e.t0), 64'(e.lat));
          last_hl = e.data;
        end
      end
    end
  end

  // Called right after a negedge; returns after the accepting edge's following negedge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
    exp_t e;
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 check("stall_on_start", {63'b0, stall_req}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (expect_it) begin
      e.data = model(o, a, b);
      e.lat  = o[1] ? 32 : 1;
      e.t0   = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 45) begin
      if (busy) check("stall_while_busy", {63'b0, stall_req}, 64'd1);
      @(negedge clk);
      n++;
    end
    if (n >= 45) begin
      check("drain_timeout", 64'(n), 64'd0);
      sb.delete();
    end
    check("busy_after", {63'b0, busy}, 64'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    launch(o, a, b, 1'b1);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; flush = 1'b0;
    #3;
    check("rst_busy",     {63'b0, busy},      64'd0);
    check("rst_valid",    {63'b0, hl_valid},  64'd0);
    check("rst_stall",    {63'b0, stall_req}, 64'd0);
    check("rst_data",     hl_data,            64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b00, 32'hFFFF_FFFE, 32'd3);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    issue(2'b11, 32'd100, 32'd7);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b11, 32'd5, 32'd0);
    issue(2'b10, 32'hFFFF_FFF0, 32'd0);

    // Flush part-way through a divide.
    launch(2'b10, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_cycle_valid", {63'b0, hl_valid}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_data_held", hl_data, last_hl);
    repeat (40) @(negedge clk);
    check("flush_data_still", hl_data, last_hl);

    // start and flush together in IDLE.
    start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    #1 check("startflush_stall", {63'b0, stall_req}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("startflush_busy", {63'b0, busy}, 64'd0);
    check("startflush_data", hl_data, last_hl);

    // start pulses and operand changes during a divide are ignored.
    launch(2'b11, 32'd100, 32'd7, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 32'h1234; src_b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Flush during DONE: result already written, but no strobe.
    launch(2'b01, 32'd6, 32'd7, 1'b0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("done_flush_valid", {63'b0, hl_valid}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("done_flush_data", hl_data, 64'd42);
    check("done_flush_busy", {63'b0, busy}, 64'd0);
    last_hl = 64'd42;

    // Asynchronous reset between edges mid-divide.
    launch(2'b10, 32'd12345, 32'd17, 1'b1);
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy",  {63'b0, busy},     64'd0);
    check("arst_valid", {63'b0, hl_valid}, 64'd0);
    check("arst_data",  hl_data,           64'd0);
    sb.delete();
    last_hl = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(2'b01, 32'd3, 32'd4);
    check("post_rst_mul", hl_data, 64'h0000_0000_0000_000C);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide engine in the EX stage.
- Produces the 64-bit {hi,lo} result and a one-cycle write strobe. Both travel through EX/MEM/WB and reach the ID-stage register file as hl_data and hl_write_enable_from_wb.
- Raises a stall request so the issuing pipeline holds while an operation is in flight.
- Drops an operation on pipeline flush (exception/eret).

Parameters:
- WIDTH, 32, operand width. Only 32 is supported. Result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset: asynchronous, active-low (0 = reset).
- start  input  1  issue request from EX. Sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  input  32  multiplicand / dividend.
- src_b  input  32  multiplier / divisor.
- flush  input  1  pipeline flush. Aborts any operation.
- busy  output  1  high whenever state is not IDLE.
- stall_req  output  1  combinational: busy | (start & ~flush).
- hl_valid  output  1  one-cycle result strobe to the pipeline.
- hl_data  output  64  result: [63:32] = hi, [31:0] = lo.

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset (rst=0, asynchronous) forces:
  - state = IDLE, iteration counter = 0.
  - hl_data = 0, hl_valid = 0, busy = 0.
- Accept: in IDLE with start=1 and flush=0, the rising edge T0 latches src_a, src_b and op.
  - op[1]=0: go to MUL.
  - op[1]=1: go to DIV with counter = 0.
  - For signed ops, operands are latched as magnitudes, with sign flags captured.
- MUL: edge T1 computes the 64-bit product, writes it to hl_data and goes to DONE.
  - MULT is signed (two's complement); MULTU is unsigned.
  - hl_valid is high in the cycle after T1.
- DIV: radix-2 restoring divider on magnitudes, one quotient bit per edge, counter 0..31.
  - The 32nd step (edge T32) writes the result and goes to DONE.
  - hl_valid is high in the cycle after T32.
  - hi = remainder, lo = quotient.
  - Signed: quotient negated if sign(a) != sign(b); remainder takes sign(a).
  - Overflow case: 0x80000000 / 0xFFFFFFFF (signed) gives lo = 0x80000000, hi = 0. This is the natural two's-complement wrap, not special-cased.
  - Divisor = 0 (both signed and unsigned): same 32-step latency; result hi = src_a, lo = 0xFFFFFFFF.
- DONE: lasts exactly one cycle, then goes to IDLE.
  - hl_valid = (state == DONE) & ~flush.
- New requests:
  - A new start is accepted only in IDLE.
  - start is ignored in MUL, DIV and DONE; the issuer is held by stall_req.
  - Back-to-back ops: earliest re-accept is the edge after DONE.
- Flush:
  - Any state goes to IDLE on the next edge. Counter is cleared; hl_data is not updated.
  - No hl_valid is produced for the aborted op.
  - start with flush in the same cycle is not accepted.
- hl_data holds the last completed result until the next completion or reset.
- Reset mid-operation: immediate return to the reset values above; no strobe.
- busy/stall_req exist so the ID stage never forwards stale hi/lo while a result is pending.

Test Plan:
- MULTU: src_a = 0xFFFFFFFF, src_b = 0xFFFFFFFF, start at T0 -> hl_valid for one cycle after T1, hl_data = 0xFFFFFFFE_00000001; busy low after.
- MULT: src_a = 0xFFFFFFFE (-2), src_b = 3 -> hl_data = 0xFFFFFFFF_FFFFFFFA; stall_req high from the start cycle through DONE.
- DIV:
  - src_a = 0xFFFFFFF9 (-7), src_b = 2 -> hl_valid only after T32, hi = 0xFFFFFFFF, lo = 0xFFFFFFFD.
  - DIVU: 100 / 7 -> hi = 2, lo = 14.
- DIV edge cases:
  - Signed 0x80000000 / 0xFFFFFFFF -> hi = 0, lo = 0x80000000.
  - DIVU 5 / 0 -> hi = 5, lo = 0xFFFFFFFF after 32 steps.
- Flush at step 10 of a DIV -> IDLE next edge, no hl_valid, hl_data unchanged.
  - start pulsed during DIV is ignored.
  - start with flush simultaneous -> not accepted.
- Assert rst=0 asynchronously mid-DIV (between edges) -> busy and hl_valid drop immediately, hl_data = 0.
  - After release, a MULTU 3×4 completes with hl_data = 0x00000000_0000000C.
